iw_encoder_movk_seq: RTL and testbench

//  Builds the instruction words that load a full 64-bit constant into Xd: one MOVZ followed by

---
 rtl/iw_encoder_movk_seq_pkg.sv | 41 ++++
 rtl/iw_encoder_movk_seq_if.sv | 25 ++
 rtl/iw_encoder_movk_seq_hw_lowest_set.sv | 18 +
 rtl/iw_encoder_movk_seq.sv | 104 ++++++++++
 tb/tb_iw_encoder_movk_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/iw_encoder_movk_seq_pkg.sv
// Shared definitions for the MOVZ/MOVK constant-load encoder.
// Instruction word layout: {op[31:23], hw[22:21], imm16[20:5], rd[4:0]}.
package iw_encoder_movk_seq_pkg;

  localparam logic [8:0] OP_MOVZ_DEFAULT = 9'h1A5;
  localparam logic [8:0] OP_MOVK_DEFAULT = 9'h1E5;

  localparam int OP_LSB  = 23;
  localparam int HW_LSB  = 21;
  localparam int IMM_LSB = 5;
  localparam int RD_LSB  = 0;

  typedef logic [31:0] iw_word_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  function automatic iw_word_t encode_iw(input logic [8:0] op, input logic [1:0] hw,
                                         input logic [15:0] imm, input logic [4:0] rd);
    iw_word_t w;
    w = (iw_word_t'(op)  << OP_LSB)
      | (iw_word_t'(hw)  << HW_LSB)
      | (iw_word_t'(imm) << IMM_LSB)
      | (iw_word_t'(rd)  << RD_LSB);
    return w;
  endfunction

  function automatic logic [15:0] sel_half(input logic [63:0] value, input logic [1:0] hw);
    logic [15:0] h;
    case (hw)
      2'd0:    h = value[15:0];
      2'd1:    h = value[31:16];
      2'd2:    h = value[47:32];
      default: h = value[63:48];
    endcase
    return h;
  endfunction

endpackage

// File: rtl/iw_encoder_movk_seq_if.sv
// Request and instruction-word stream handshake bundle for the encoder.
interface iw_encoder_movk_seq_if;
  import iw_encoder_movk_seq_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_value;
  logic [4:0]  req_rd;
  logic        iw_valid;
  logic        iw_ready;
  iw_word_t    iw_data;
  logic        iw_last;

  // Loader / instruction-memory side
  modport master (
    output req_valid, req_value, req_rd, iw_ready,
    input  req_ready, iw_valid, iw_data, iw_last
  );

  // Encoder side
  modport slave (
    input  req_valid, req_value, req_rd, iw_ready,
    output req_ready, iw_valid, iw_data, iw_last
  );
endinterface

// File: rtl/iw_encoder_movk_seq_hw_lowest_set.sv
// Finds the lowest set bit of a 4-bit halfword mask; idx is 0 when the mask is empty.
module hw_lowest_set (
  input  logic [3:0] mask_i,
  output logic [1:0] idx_o,
  output logic       any_o
);

  // Priority encode from bit 0 upward so halfwords are emitted in ascending order
  always_comb begin
    idx_o = 2'd0;
    any_o = |mask_i;
    if (mask_i[0])      idx_o = 2'd0;
    else if (mask_i[1]) idx_o = 2'd1;
    else if (mask_i[2]) idx_o = 2'd2;
    else if (mask_i[3]) idx_o = 2'd3;
  end

endmodule

// File: rtl/iw_encoder_movk_seq.sv
// Emits one MOVZ plus up to three MOVK words that load a 64-bit constant into Xd.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EMIT  | presenting the word for the lowest pending halfword
module iw_encoder_movk_seq
  import iw_encoder_movk_seq_pkg::*;
#(
  parameter bit         SKIP_ZERO_HW = 1'b1,
  parameter logic [8:0] MOVZ_OP      = OP_MOVZ_DEFAULT,
  parameter logic [8:0] MOVK_OP      = OP_MOVK_DEFAULT
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  iw_encoder_movk_seq_if.slave  bus,
  output logic                  busy_o
);

  state_e      state_q, state_d;
  logic [63:0] value_q, value_d;
  logic [4:0]  rd_q,    rd_d;
  logic [3:0]  mask_q,  mask_d;
  logic        first_q, first_d;

  logic [1:0]  low_idx;
  logic        low_any;
  logic [3:0]  mask_rem;
  logic        last_word;
  logic [3:0]  req_mask;

  hw_lowest_set u_lowest (
    .mask_i (mask_q),
    .idx_o  (low_idx),
    .any_o  (low_any)
  );

  // Pending mask once the current word has gone; an empty mask (value 0) still yields one MOVZ
  always_comb begin
    mask_rem  = low_any ? (mask_q & ~(4'b0001 << low_idx)) : mask_q;
    last_word = (mask_rem == 4'd0);
    for (int i = 0; i < 4; i++) begin
      req_mask[i] = SKIP_ZERO_HW ? (bus.req_value[16*i +: 16] != 16'd0) : 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      value_q <= 64'd0;
      rd_q    <= 5'd0;
      mask_q  <= 4'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      first_q <= first_d;
    end
  end

  // Next-state and outputs; the word is decoded only from registered state
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    first_d = first_q;

    bus.req_ready = 1'b0;
    bus.iw_valid  = 1'b0;
    bus.iw_last   = 1'b0;
    bus.iw_data   = '0;
    busy_o        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          value_d = bus.req_value;
          rd_d    = bus.req_rd;
          mask_d  = req_mask;
          first_d = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        busy_o       = 1'b1;
        bus.iw_valid = 1'b1;
        bus.iw_last  = last_word;
        bus.iw_data  = encode_iw(first_q ? MOVZ_OP : MOVK_OP, low_idx,
                                 low_any ? sel_half(value_q, low_idx) : 16'd0, rd_q);
        if (bus.iw_ready) begin
          mask_d  = mask_rem;
          first_d = 1'b0;
          if (last_word) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iw_encoder_movk_seq.sv
// Bench for the MOVZ/MOVK constant-load encoder (one DUT skipping zero halfwords, one not).
module tb_iw_encoder_movk_seq;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  iw_encoder_movk_seq_if ifa ();
  iw_encoder_movk_seq_if ifb ();
  logic busy_a, busy_b;

  iw_encoder_movk_seq #(.SKIP_ZERO_HW(1'b1)) u_dut (
    .clock_i(clock), .reset_n_i(reset_n), .bus(ifa.slave), .busy_o(busy_a));

  iw_encoder_movk_seq #(.SKIP_ZERO_HW(1'b0)) u_dut_noskip (
    .clock_i(clock), .reset_n_i(reset_n), .bus(ifb.slave), .busy_o(busy_b));

  int total = 0;
  int bad   = 0;

  // Reference: list the halfwords to load, first is MOVZ, the rest MOVK
  task automatic model_words(input logic [63:0] val, input logic [4:0] rd, input bit skip,
                             output logic [31:0] words[$]);
    int unsigned hws[$];
    int unsigned imm, op, w;
    words.delete();
    for (int h = 0; h < 4; h++) begin
      imm = int'((val >> (16 * h)) % 65536);
      if (!skip || imm != 0) hws.push_back(h);
    end
    if (hws.size() == 0) hws.push_back(0);
    foreach (hws[i]) begin
      imm = int'((val >> (16 * hws[i])) % 65536);
      op  = (i == 0) ? 32'h1A5 : 32'h1E5;
      w   = op * 8388608 + hws[i] * 2097152 + imm * 32 + int'(rd);
      words.push_back(w);
    end
  endtask

  task automatic drive_req(input bit which, input logic v, input logic [63:0] val, input logic [4:0] rd);
    if (which) begin ifb.req_valid = v; ifb.req_value = val; ifb.req_rd = rd; end
    else       begin ifa.req_valid = v; ifa.req_value = val; ifa.req_rd = rd; end
  endtask

  task automatic drive_ready(input bit which, input logic r);
    if (which) ifb.iw_ready = r; else ifa.iw_ready = r;
  endtask

  // {iw_valid, iw_last, req_ready, busy, iw_data}
  function automatic logic [35:0] snap(input bit which);
    if (which) return {ifb.iw_valid, ifb.iw_last, ifb.req_ready, busy_b, ifb.iw_data};
    return {ifa.iw_valid, ifa.iw_last, ifa.req_ready, busy_a, ifa.iw_data};
  endfunction

  // Issue one request and consume its words; stall cycles of iw_ready=0 before each word
  task automatic run_seq(input string tag, input bit which, input logic [63:0] val,
                         input logic [4:0] rd, input logic [31:0] exp[$],
                         input int stall, input bit rand_stall, input bit noise);
    int n;
    int st;
    logic [35:0] got, want;
    n = 0;
    while (snap(which)[33] !== 1'b1 && n < 20) begin
      @(posedge clock); @(negedge clock); n++;
    end
    total++;
    if (snap(which)[33] !== 1'b1) begin
      bad++;
      $display("FAIL %s req_ready_wait got=%b want=1", tag, snap(which)[33]);
      return;
    end
    drive_req(which, 1'b1, val, rd);
    @(posedge clock); @(negedge clock);
    drive_req(which, 1'b0, 64'({$urandom, $urandom}), 5'($urandom));
    foreach (exp[i]) begin
      st = rand_stall ? int'($urandom_range(stall, 0)) : stall;
      want = {1'b1, (i == exp.size() - 1), 1'b0, 1'b1, exp[i]};
      for (int s = 0; s < st; s++) begin
        drive_ready(which, 1'b0);
        if (noise && i == 0) drive_req(which, 1'b1, 64'({$urandom, $urandom}), 5'($urandom));
        got = snap(which);
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL %s stall word%0d cyc%0d got=%h want=%h", tag, i, s, got, want);
        end
        @(posedge clock); @(negedge clock);
        drive_req(which, 1'b0, 64'd0, 5'd0);
      end
      drive_ready(which, 1'b1);
      got = snap(which);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s word%0d got=%h want=%h", tag, i, got, want);
      end
      @(posedge clock); @(negedge clock);
    end
    drive_ready(which, 1'b0);
    got = snap(which);
    total++;
    if ({got[35], got[33], got[32]} !== 3'b010) begin
      bad++;
      $display("FAIL %s end valid/req_ready/busy got=%b want=010", tag, {got[35], got[33], got[32]});
    end
  endtask

  task automatic test_reset();
    logic [35:0] g;
    drive_req(1'b0, 1'b0, 64'd0, 5'd0); drive_req(1'b1, 1'b0, 64'd0, 5'd0);
    drive_ready(1'b0, 1'b0); drive_ready(1'b1, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    g = snap(1'b0);
    total++;
    if ({g[35], g[34], g[32], g[31:0]} !== 35'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {g[35], g[34], g[32], g[31:0]});
    end
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    total++;
    if ({snap(1'b0)[33], snap(1'b1)[33]} !== 2'b11) begin
      bad++; $display("FAIL reset_req_ready got=%b want=11", {snap(1'b0)[33], snap(1'b1)[33]});
    end
  endtask

  task automatic test_directed();
    logic [31:0] q[$];
    q.delete(); q.push_back(32'hD2800003);
    run_seq("zero", 1'b0, 64'd0, 5'd3, q, 0, 1'b0, 1'b0);
    q.delete(); q.push_back(32'hD2824680);
    run_seq("low_only", 1'b0, 64'h1234, 5'd0, q, 0, 1'b0, 1'b0);
    q.delete(); q.push_back(32'hD297DDE5); q.push_back(32'hF2FBD5A5);
    run_seq("two_word", 1'b0, 64'hDEAD_0000_0000_BEEF, 5'd5, q, 0, 1'b0, 1'b0);
    q.delete(); q.push_back(32'hD2FFFFE1);
    run_seq("top_only", 1'b0, 64'hFFFF_0000_0000_0000, 5'd1, q, 0, 1'b0, 1'b0);
  endtask

  task automatic test_no_skip();
    logic [31:0] q[$];
    logic [63:0] v;
    q.delete();
    q.push_back(32'hD2800001); q.push_back(32'hF2A00001);
    q.push_back(32'hF2C00001); q.push_back(32'hF2FFFFE1);
    run_seq("noskip_top", 1'b1, 64'hFFFF_0000_0000_0000, 5'd1, q, 0, 1'b0, 1'b0);
    v = 64'({$urandom, $urandom});
    model_words(v, 5'd31, 1'b0, q);
    run_seq("noskip_rand", 1'b1, v, 5'd31, q, 1, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    q.delete(); q.push_back(32'hD297DDE5); q.push_back(32'hF2FBD5A5);
    run_seq("backpressure", 1'b0, 64'hDEAD_0000_0000_BEEF, 5'd5, q, 3, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [31:0] q[$];
    logic [35:0] g;
    ifa.req_valid = 1'b1; ifa.req_value = 64'hDEAD_0000_0000_BEEF; ifa.req_rd = 5'd5;
    @(posedge clock); @(negedge clock);
    ifa.req_valid = 1'b0; ifa.iw_ready = 1'b1;
    g = snap(1'b0);
    total++;
    if (g !== {4'b1001, 32'hD297DDE5}) begin
      bad++; $display("FAIL midreset_first got=%h want=%h", g, {4'b1001, 32'hD297DDE5});
    end
    @(posedge clock); @(negedge clock);
    ifa.iw_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); @(negedge clock);
    g = snap(1'b0);
    total++;
    if ({g[35], g[32]} !== 2'b00) begin
      bad++; $display("FAIL midreset_flush valid/busy got=%b want=00", {g[35], g[32]});
    end
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    g = snap(1'b0);
    total++;
    if ({g[35], g[33], g[32]} !== 3'b010) begin
      bad++; $display("FAIL midreset_release got=%b want=010", {g[35], g[33], g[32]});
    end
    q.delete(); q.push_back(32'hD2824680);
    run_seq("after_reset", 1'b0, 64'h1234, 5'd0, q, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [63:0] v;
    logic [4:0]  rd;
    for (int it = 0; it < 30; it++) begin
      v = 64'({$urandom, $urandom});
      for (int h = 0; h < 4; h++) if ($urandom_range(1, 0) == 0) v[16*h +: 16] = 16'd0;
      rd = 5'($urandom);
      model_words(v, rd, 1'b1, q);
      run_seq($sformatf("rand%0d", it), 1'b0, v, rd, q, 2, 1'b1, 1'($urandom));
    end
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_value = '0; ifa.req_rd = '0; ifa.iw_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_value = '0; ifb.req_rd = '0; ifb.iw_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_directed();
    test_no_skip();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
